// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronizer, debounce FSM with registered terminal-count
// compare, press counter and long-press detector. Every output is a flop.
module btn_debounce #(
  parameter int SYNC_STAGES    = 3,
  parameter int DEBOUNCE_TICKS = 3330000,
  parameter int LONG_TICKS     = 333000000,
  parameter int CNT_BITS       = 40,
  parameter int PRESS_BITS     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_in,
  output logic                  btn_level,
  output logic                  btn_rise,
  output logic                  btn_fall,
  output logic                  btn_long,
  output logic                  btn_hold,
  output logic [PRESS_BITS-1:0] press_count
);

  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} state_t;

  localparam logic [CNT_BITS-1:0] DB_LAST   = CNT_BITS'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_BITS-1:0] LONG_LAST = CNT_BITS'(LONG_TICKS - 1);
  localparam logic [CNT_BITS-1:0] LONG_SAT  = CNT_BITS'(LONG_TICKS);

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [CNT_BITS-1:0]     db_cnt_q, db_cnt_d;
  logic                    db_hit_q, db_hit_d;
  logic [CNT_BITS-1:0]     long_cnt_q, long_cnt_d;
  logic                    level_q, level_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;
  logic                    long_q, long_d;
  logic                    hold_q, hold_d;
  logic [PRESS_BITS-1:0]   press_q, press_d;
  logic                    btn_s;
  logic                    long_active;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
  assign btn_s  = sync_q[SYNC_STAGES-1];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE_LO;
    else       state_q <= state_d;
  end

  // Next state; db_hit_q is the terminal-count compare registered one cycle early,
  // so the wide compare never sits in the same path as the state decode.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = '0;
    db_hit_d = 1'b0;
    case (state_q)
      IDLE_LO: if (btn_s) state_d = WAIT_HI;
      WAIT_HI: begin
        if (!btn_s)        state_d = IDLE_LO;
        else if (db_hit_q) state_d = IDLE_HI;
        else begin
          db_cnt_d = db_cnt_q + CNT_BITS'(1);
          db_hit_d = (db_cnt_q == DB_LAST);
        end
      end
      IDLE_HI: if (!btn_s) state_d = WAIT_LO;
      WAIT_LO: begin
        if (btn_s)         state_d = IDLE_HI;
        else if (db_hit_q) state_d = IDLE_LO;
        else begin
          db_cnt_d = db_cnt_q + CNT_BITS'(1);
          db_hit_d = (db_cnt_q == DB_LAST);
        end
      end
      default: state_d = IDLE_LO;
    endcase
  end

  // Outputs are decoded from the transition and registered alongside the state
  always_comb begin
    long_active = (state_q == IDLE_HI) || (state_q == WAIT_LO);
    level_d     = (state_d == IDLE_HI) || (state_d == WAIT_LO);
    rise_d      = (state_q == WAIT_HI) && (state_d == IDLE_HI);
    fall_d      = (state_q == WAIT_LO) && (state_d == IDLE_LO);
    press_d     = press_q + PRESS_BITS'(rise_d);
    long_cnt_d  = long_cnt_q;
    if (rise_d)
      long_cnt_d = '0;
    else if (long_active && (long_cnt_q != LONG_SAT))
      long_cnt_d = long_cnt_q + CNT_BITS'(1);
    long_d = long_active && (long_cnt_q == LONG_LAST);
    hold_d = hold_q;
    if (fall_d)      hold_d = 1'b0;
    else if (long_d) hold_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      db_cnt_q   <= '0;
      db_hit_q   <= 1'b0;
      long_cnt_q <= '0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      long_q     <= 1'b0;
      hold_q     <= 1'b0;
      press_q    <= '0;
    end else begin
      sync_q     <= sync_d;
      db_cnt_q   <= db_cnt_d;
      db_hit_q   <= db_hit_d;
      long_cnt_q <= long_cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      long_q     <= long_d;
      hold_q     <= hold_d;
      press_q    <= press_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_rise    = rise_q;
  assign btn_fall    = fall_q;
  assign btn_long    = long_q;
  assign btn_hold    = hold_q;
  assign press_count = press_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: expected rise/fall/long events are queued with their
// cycle and press count when the button is driven, and matched as the DUT emits them.
module tb_btn_debounce;

  localparam int SYNC_STAGES    = 2;
  localparam int DEBOUNCE_TICKS = 8;
  localparam int LONG_TICKS     = 20;
  localparam int CNT_BITS       = 40;
  localparam int PRESS_BITS     = 4;
  localparam int LAT            = SYNC_STAGES + DEBOUNCE_TICKS + 1;

  localparam logic [3:0] EV_RISE = 4'd1;
  localparam logic [3:0] EV_FALL = 4'd2;
  localparam logic [3:0] EV_LONG = 4'd3;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  btn_in = 1'b0;
  logic                  btn_level, btn_rise, btn_fall, btn_long, btn_hold;
  logic [PRESS_BITS-1:0] press_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_seen = 0;
  int e0, r, f, base;
  logic [3:0]  exp_press;
  logic [39:0] exp_q[$];   // {kind[3:0], press[3:0], cycle[31:0]}

  btn_debounce #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_TICKS(DEBOUNCE_TICKS), .LONG_TICKS(LONG_TICKS),
    .CNT_BITS(CNT_BITS), .PRESS_BITS(PRESS_BITS)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall),
    .btn_long(btn_long), .btn_hold(btn_hold), .press_count(press_count)
  );

  // Clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_evt(input logic [3:0] kind, input int at);
    exp_q.push_back({kind, exp_press, 32'(at)});
  endtask

  task automatic match_evt(input logic [3:0] kind);
    logic [39:0] ev;
    if (exp_q.size() == 0) begin
      check_eq("unexpected_evt", 32'(kind), 32'd0);
    end else begin
      ev = exp_q.pop_front();
      check_eq("evt_kind", 32'(kind), 32'(ev[39:36]));
      check_eq("evt_cycle", cyc, ev[31:0]);
      check_eq("evt_press", 32'(press_count), 32'(ev[35:32]));
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [39:0] ev;
    if (!reset) begin
      if (btn_rise || btn_fall) check_eq("rise_fall_excl", 32'(btn_rise & btn_fall), 32'd0);
      if (btn_rise) begin
        rise_seen++;
        match_evt(EV_RISE);
        check_eq("rise_level", 32'(btn_level), 32'd1);
      end
      if (btn_fall) begin
        match_evt(EV_FALL);
        check_eq("fall_level", 32'(btn_level), 32'd0);
        check_eq("fall_hold", 32'(btn_hold), 32'd0);
      end
      if (btn_long) begin
        match_evt(EV_LONG);
        check_eq("long_hold", 32'(btn_hold), 32'd1);
      end
      if (exp_q.size() > 0 && exp_q[0][31:0] < 32'(cyc)) begin
        ev = exp_q.pop_front();
        check_eq("missed_evt_at", ev[31:0], cyc);
      end
    end
  end

  // Driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drive_btn(input logic v, output int edge0);
    btn_in = v;
    edge0  = cyc + 1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got=%0d exp=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    exp_press = '0;
    wait_cyc(3);
    check_eq("rst_level", 32'(btn_level), 32'd0);
    check_eq("rst_rise", 32'(btn_rise), 32'd0);
    check_eq("rst_fall", 32'(btn_fall), 32'd0);
    check_eq("rst_long", 32'(btn_long), 32'd0);
    check_eq("rst_hold", 32'(btn_hold), 32'd0);
    check_eq("rst_press", 32'(press_count), 32'd0);
    reset = 1'b0;
    wait_cyc(2);

    // Clean press held long, then clean release
    drive_btn(1'b1, e0);
    r = e0 + LAT;
    exp_press++;
    push_evt(EV_RISE, r);
    push_evt(EV_LONG, r + LONG_TICKS);
    wait_until(r - 1);
    check_eq("a_pre_level", 32'(btn_level), 32'd0);
    wait_until(r + 1);
    check_eq("a_level", 32'(btn_level), 32'd1);
    check_eq("a_rise_1cyc", 32'(btn_rise), 32'd0);
    check_eq("a_press", 32'(press_count), 32'd1);
    wait_until(r + LONG_TICKS - 1);
    check_eq("a_pre_hold", 32'(btn_hold), 32'd0);
    wait_until(r + LONG_TICKS + 1);
    check_eq("a_hold", 32'(btn_hold), 32'd1);
    wait_until(r + 50);
    drive_btn(1'b0, e0);
    f = e0 + LAT;
    push_evt(EV_FALL, f);
    wait_until(f - 1);
    check_eq("a_pre_fall_hold", 32'(btn_hold), 32'd1);
    check_eq("a_pre_fall_level", 32'(btn_level), 32'd1);
    wait_until(f + 1);
    check_eq("a_rel_level", 32'(btn_level), 32'd0);
    check_eq("a_rel_hold", 32'(btn_hold), 32'd0);

    // Glitchy press; release with a high bounce inside WAIT_LO
    wait_cyc(3);
    drive_btn(1'b1, e0);
    wait_cyc(7);
    drive_btn(1'b0, e0);
    wait_cyc(3);
    drive_btn(1'b1, e0);
    r = e0 + LAT;
    exp_press++;
    push_evt(EV_RISE, r);
    push_evt(EV_LONG, r + LONG_TICKS);
    wait_until(r - 1);
    check_eq("b_pre_level", 32'(btn_level), 32'd0);
    wait_until(r + 1);
    check_eq("b_press", 32'(press_count), 32'd2);
    wait_until(r + 5);
    drive_btn(1'b0, e0);
    wait_cyc(4);
    drive_btn(1'b1, e0);
    wait_cyc(5);
    drive_btn(1'b0, e0);
    f = e0 + LAT;
    push_evt(EV_FALL, f);
    wait_until(f + 2);
    check_eq("b_level", 32'(btn_level), 32'd0);
    check_eq("b_hold", 32'(btn_hold), 32'd0);
    check_eq("b_press_kept", 32'(press_count), 32'd2);

    // Reset during WAIT_HI with the button held
    wait_cyc(3);
    drive_btn(1'b1, e0);
    wait_cyc(5);
    reset = 1'b1;
    wait_cyc(2);
    check_eq("c_rst_level", 32'(btn_level), 32'd0);
    check_eq("c_rst_rise", 32'(btn_rise), 32'd0);
    check_eq("c_rst_press", 32'(press_count), 32'd0);
    reset = 1'b0;
    exp_press = '0;
    e0 = cyc + 1;
    r = e0 + LAT;
    exp_press++;
    push_evt(EV_RISE, r);
    wait_until(r - 1);
    check_eq("c_pre_level", 32'(btn_level), 32'd0);
    wait_until(r + 1);
    check_eq("c_level", 32'(btn_level), 32'd1);
    check_eq("c_press", 32'(press_count), 32'd1);
    wait_until(r + 3);
    drive_btn(1'b0, e0);
    f = e0 + LAT;
    push_evt(EV_FALL, f);
    wait_until(f + 2);

    // Press counter wrap over 17 short presses
    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    exp_press = '0;
    base = rise_seen;
    for (int i = 0; i < 17; i++) begin
      drive_btn(1'b1, e0);
      r = e0 + LAT;
      exp_press++;
      push_evt(EV_RISE, r);
      wait_until(r + 2);
      drive_btn(1'b0, e0);
      f = e0 + LAT;
      push_evt(EV_FALL, f);
      wait_until(f + 2);
      check_eq("wrap_press", 32'(press_count), 32'((i + 1) % 16));
    end
    check_eq("wrap_rise_count", 32'(rise_seen - base), 32'd17);

    wait_cyc(30);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
